// File: rtl/floo_rd_resp_pkg.sv
// Shared types and constants for the FlooNoC AXI read responder.
// Holds the responder FSM state enum, AXI burst/response encodings, the
// per-request control descriptor stored in the pending table, and the
// shuffle-LFSR tap constant with its step function.
package floo_rd_resp_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_resp_state_e;

  // AXI burst encodings
  localparam logic [1:0] BurstFixed = 2'd0;
  localparam logic [1:0] BurstIncr  = 2'd1;
  localparam logic [1:0] BurstWrap  = 2'd2;
  localparam logic [1:0] BurstRsvd  = 2'd3;

  // AXI response encodings
  localparam logic [1:0] RespOkay   = 2'd0;
  localparam logic [1:0] RespSlvErr = 2'd2;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Width-independent part of a pending AR request
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } rd_req_ctrl_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], ^(l & LfsrTaps)};
  endfunction

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/floo_axi_rd_responder_age.sv
// floo_age_matrix: relative-age tracking for the pending table.
// Row i bit j set means entry j arrived before entry i.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   insert_i/insert_idx_i new request written into a free entry
//   free_i/free_idx_i     entry released after its last beat
//   valid_i               current occupancy vector
//   ids_i                 AXI ID of every entry
//   eligible_i            entries currently allowed to be served
//   older_same_id_o       entry has an older valid entry with the same ID
//   older_eligible_o      entry has an older eligible entry
module floo_age_matrix #(
  parameter int unsigned NumPending = 8,
  parameter int unsigned IdWidth    = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 insert_i,
  input  logic [$clog2(NumPending)-1:0]        insert_idx_i,
  input  logic                                 free_i,
  input  logic [$clog2(NumPending)-1:0]        free_idx_i,
  input  logic [NumPending-1:0]                valid_i,
  input  logic [NumPending-1:0][IdWidth-1:0]   ids_i,
  input  logic [NumPending-1:0]                eligible_i,
  output logic [NumPending-1:0]                older_same_id_o,
  output logic [NumPending-1:0]                older_eligible_o
);

  logic [NumPending-1:0][NumPending-1:0] age_q, age_d;

  // Freed entry leaves every row; a new entry sees all present entries as older
  always_comb begin
    age_d = age_q;
    if (free_i) begin
      for (int i = 0; i < NumPending; i++) age_d[i][free_idx_i] = 1'b0;
    end
    if (insert_i) begin
      age_d[insert_idx_i] = valid_i;
      if (free_i) age_d[insert_idx_i][free_idx_i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) age_q <= '0;
    else       age_q <= age_d;
  end

  // Per-ID ordering blocker
  always_comb begin
    older_same_id_o = '0;
    for (int i = 0; i < NumPending; i++) begin
      for (int j = 0; j < NumPending; j++) begin
        if (age_q[i][j] && valid_i[j] && (ids_i[j] == ids_i[i])) older_same_id_o[i] = 1'b1;
      end
    end
  end

  // Kept in its own block: eligible_i is derived from older_same_id_o
  always_comb begin
    older_eligible_o = '0;
    for (int i = 0; i < NumPending; i++) begin
      for (int j = 0; j < NumPending; j++) begin
        if (age_q[i][j] && eligible_i[j]) older_eligible_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/floo_axi_rd_responder.sv
// floo_axi_rd_responder: AXI4 read subordinate for FlooNoC initiators.
// Queues up to NumPending AR requests and returns one R burst at a time whose
// data is the beat address replicated across the data bus. Order is kept per
// ID; bursts of different IDs may be reordered.
// Optional feature macro FLOO_RD_RESP_SHUFFLE_EN: when defined, a 16-bit LFSR
// picks a random circular start point for cross-ID selection; otherwise the
// oldest eligible request is served (global AR order).
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   ar_*                AXI AR channel (subordinate side)
//   r_*                 AXI R channel (subordinate side)
//   num_pending_o       occupied table entries, including the one in service
module floo_axi_rd_responder
  import floo_rd_resp_pkg::*;
#(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned NumPending = 8,
  parameter logic [15:0] LfsrSeed   = 16'hACE1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              ar_valid_i,
  output logic                              ar_ready_o,
  input  logic [IdWidth-1:0]                ar_id_i,
  input  logic [AddrWidth-1:0]              ar_addr_i,
  input  logic [7:0]                        ar_len_i,
  input  logic [2:0]                        ar_size_i,
  input  logic [1:0]                        ar_burst_i,
  output logic                              r_valid_o,
  input  logic                              r_ready_i,
  output logic [IdWidth-1:0]                r_id_o,
  output logic [DataWidth-1:0]              r_data_o,
  output logic [1:0]                        r_resp_o,
  output logic                              r_last_o,
  output logic [$clog2(NumPending+1)-1:0]   num_pending_o
);

  localparam int unsigned IdxW  = $clog2(NumPending);
  localparam int unsigned CntW  = $clog2(NumPending + 1);
  localparam int unsigned Lanes = DataWidth / AddrWidth;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    rd_req_ctrl_t         ctrl;
  } entry_t;

  if ((NumPending < 2) || (NumPending > 32)) begin : g_bad_depth
    $error("NumPending must be in 2..32");
  end
  if ((DataWidth % AddrWidth) != 0) begin : g_bad_width
    $error("DataWidth must be a multiple of AddrWidth");
  end
  if (LfsrSeed == 16'h0) begin : g_bad_seed
    $error("LfsrSeed must be nonzero");
  end

  // Pending table
  entry_t                  table_q [NumPending];
  logic [NumPending-1:0]   valid_q, valid_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    ready_q, ready_d;
  logic [IdxW-1:0]         ins_idx;
  logic                    ar_hs;

  // Burst registers
  rd_resp_state_e          state_q, state_d;
  logic [IdxW-1:0]         served_q, served_d;
  logic [IdWidth-1:0]      rid_q, rid_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  rd_req_ctrl_t            ctrl_q, ctrl_d;
  logic [7:0]              beat_q, beat_d;
  logic [1:0]              resp_q, resp_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rlast_q, rlast_d;
  logic                    free;

  // Selection
  logic [NumPending-1:0]              serving, eligible, older_same_id, older_eligible;
  logic [NumPending-1:0][IdWidth-1:0] ids;
  logic                               pick_valid;
  logic [IdxW-1:0]                    pick_idx;
  entry_t                             pick_e;

  assign ar_hs = ar_valid_i && ready_q;

  // Lowest-index free entry
  always_comb begin
    ins_idx = '0;
    for (int i = NumPending - 1; i >= 0; i--) begin
      if (!valid_q[i]) ins_idx = IdxW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < NumPending; i++) ids[i] = table_q[i].id;
  end

  assign serving  = (state_q == BURST) ? (NumPending'(1) << served_q) : '0;
  assign eligible = valid_q & ~serving & ~older_same_id;

  floo_age_matrix #(
    .NumPending (NumPending),
    .IdWidth    (IdWidth)
  ) i_age (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .insert_i         (ar_hs),
    .insert_idx_i     (ins_idx),
    .free_i           (free),
    .free_idx_i       (served_q),
    .valid_i          (valid_q),
    .ids_i            (ids),
    .eligible_i       (eligible),
    .older_same_id_o  (older_same_id),
    .older_eligible_o (older_eligible)
  );

`ifdef FLOO_RD_RESP_SHUFFLE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 lfsr_q <= LfsrSeed;
    else if (state_q == IDLE)  lfsr_q <= lfsr_step(lfsr_q);
  end

  // First eligible entry at or after the LFSR start point, circularly
  always_comb begin
    int unsigned start;
    int unsigned pos;
    logic [IdxW-1:0] pos_idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    start      = int'(lfsr_q[IdxW-1:0]) % NumPending;
    pos        = 0;
    pos_idx    = '0;
    for (int k = NumPending - 1; k >= 0; k--) begin
      pos     = (start + k) % NumPending;
      pos_idx = IdxW'(pos);
      if (eligible[pos_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = pos_idx;
      end
    end
  end
`else
  // Exactly one eligible entry has no older eligible entry
  always_comb begin
    logic [NumPending-1:0] oldest;
    oldest     = eligible & ~older_eligible;
    pick_valid = |eligible;
    pick_idx   = '0;
    for (int i = NumPending - 1; i >= 0; i--) begin
      if (oldest[i]) pick_idx = IdxW'(i);
    end
  end
`endif

  assign pick_e = table_q[pick_idx];

  // Next beat address
  logic [AddrWidth-1:0] incr, wrap_mask, addr_inc, addr_nxt;
  always_comb begin
    incr      = AddrWidth'(1) << ctrl_q.size;
    wrap_mask = ((AddrWidth'(ctrl_q.len) + AddrWidth'(1)) << ctrl_q.size) - AddrWidth'(1);
    addr_inc  = addr_q + incr;
    addr_nxt  = addr_inc;
    case (ctrl_q.burst)
      BurstFixed: addr_nxt = addr_q;
      BurstWrap:  if (wrap_len_ok(ctrl_q.len)) addr_nxt = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default:    ;
    endcase
  end

  // FSM next state and burst register updates
  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    rid_d    = rid_q;
    addr_d   = addr_q;
    ctrl_d   = ctrl_q;
    beat_d   = beat_q;
    resp_d   = resp_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    free     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d  = BURST;
          served_d = pick_idx;
          rid_d    = pick_e.id;
          addr_d   = pick_e.addr;
          ctrl_d   = pick_e.ctrl;
          beat_d   = 8'd0;
          rvalid_d = 1'b1;
          rlast_d  = (pick_e.ctrl.len == 8'd0);
          resp_d   = ((pick_e.ctrl.burst == BurstRsvd) ||
                      ((pick_e.ctrl.burst == BurstWrap) && !wrap_len_ok(pick_e.ctrl.len)))
                     ? RespSlvErr : RespOkay;
        end
      end
      BURST: begin
        if (r_ready_i) begin
          if (beat_q == ctrl_q.len) begin
            free     = 1'b1;
            state_d  = IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_nxt;
            rlast_d = ((beat_q + 8'd1) == ctrl_q.len);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy; ready reflects next-cycle fullness so a freed slot opens next cycle
  always_comb begin
    valid_d = valid_q;
    if (free)  valid_d[served_q] = 1'b0;
    if (ar_hs) valid_d[ins_idx]  = 1'b1;
    count_d = count_q + CntW'(ar_hs) - CntW'(free);
    ready_d = (count_d != CntW'(NumPending));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumPending; i++) table_q[i] <= '0;
      valid_q <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (ar_hs) begin
        table_q[ins_idx] <= '{id: ar_id_i, addr: ar_addr_i,
                              ctrl: '{len: ar_len_i, size: ar_size_i, burst: ar_burst_i}};
      end
      valid_q <= valid_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      served_q <= '0;
      rid_q    <= '0;
      addr_q   <= '0;
      ctrl_q   <= '0;
      beat_q   <= '0;
      resp_q   <= RespOkay;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      served_q <= served_d;
      rid_q    <= rid_d;
      addr_q   <= addr_d;
      ctrl_q   <= ctrl_d;
      beat_q   <= beat_d;
      resp_q   <= resp_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
    end
  end

  assign ar_ready_o    = ready_q;
  assign r_valid_o     = rvalid_q;
  assign r_id_o        = rid_q;
  assign r_data_o      = {Lanes{addr_q}};
  assign r_resp_o      = resp_q;
  assign r_last_o      = rlast_q;
  assign num_pending_o = count_q;

endmodule
